// File: rtl/exec_seq_pkg.sv
// exec_seq_pkg
//   Shared definitions for the instruction-execution sequencer:
//   sequencer state encoding, the default NOP word (RV32I addi x0,x0,0)
//   and the width helper used for FIFO occupancy counters.
package exec_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DUMP = 2'd2
    } seq_state_t;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/exec_sequencer_fifo.sv
// inst_fifo
//   Synchronous first-word-fall-through FIFO for received instructions.
//   rdata always shows the head entry; pop consumes it on the rising edge.
//   Push and pop in the same cycle are both honoured, including when full
//   (the slot freed by the pop is reused). Pushing into a full FIFO without
//   a pop is ignored here; the owner decides how to report that.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write wdata at the tail
//   pop    in   consume the head entry
//   wdata  in   INST_W  data to write
//   rdata  out  INST_W  head entry (valid while !empty)
//   count  out  occupancy, 0..FIFO_DEPTH
//   full   out  count == FIFO_DEPTH
//   empty  out  count == 0
module inst_fifo
    import exec_seq_pkg::*;
#(
    parameter int INST_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [INST_W-1:0]               wdata,
    output logic [INST_W-1:0]               rdata,
    output logic [cnt_w(FIFO_DEPTH)-1:0]    count,
    output logic                            full,
    output logic                            empty
);

    localparam int CNT_W = cnt_w(FIFO_DEPTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [INST_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer
//   Buffers instructions from the UART receiver and runs each one on the
//   processor through a cpu_en window of EXEC_CYCLES cycles. The instruction
//   is presented for the first HOLD_CYCLES cycles of the window and NOP for
//   the rest. After a window the sequencer requests a register-file dump and
//   waits for the transmitter's dump_ready. Instructions arriving with the
//   queue full are dropped and flagged in the sticky overflow bit.
//
//   Optional feature macro: EXEC_SEQ_BATCH_EN
//     defined   - queued instructions run back-to-back with cpu_en held high;
//                 one dump is requested once the queue has drained.
//     undefined - a dump follows every instruction.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset; aborts and flushes
//   inst_valid  in   one-cycle strobe, inst_data holds an instruction
//   inst_data   in   INST_W  received instruction
//   inst_ready  out  queue not full (informational, receiver cannot stall)
//   cpu_en      out  processor clock enable (registered)
//   inst_out    out  INST_W  instruction word to processor (registered)
//   dump_req    out  register-file dump request (registered)
//   dump_ready  in   transmitter accepts the dump
//   busy        out  sequencer active or queue not empty
//   overflow    out  sticky, an instruction was dropped
//   fifo_count  out  queue occupancy
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting; pops the queue head as soon as one is available
// EXEC  | window running, cyc counts 0..EXEC_CYCLES-1
// DUMP  | requesting a register dump until dump_ready is sampled
//
// Every registered output is decoded from the state of the previous cycle,
// so cpu_en, inst_out and dump_req trail the state register by one clock.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int                INST_W      = 32,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                EXEC_CYCLES = 10,
    parameter int                HOLD_CYCLES = 2,
    parameter logic [INST_W-1:0] NOP         = INST_W'(NOP_DEFAULT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            inst_valid,
    input  logic [INST_W-1:0]               inst_data,
    output logic                            inst_ready,
    output logic                            cpu_en,
    output logic [INST_W-1:0]               inst_out,
    output logic                            dump_req,
    input  logic                            dump_ready,
    output logic                            busy,
    output logic                            overflow,
    output logic [cnt_w(FIFO_DEPTH)-1:0]    fifo_count
);

    localparam int             CYC_W    = $clog2(EXEC_CYCLES);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(EXEC_CYCLES - 1);
    localparam logic [CYC_W-1:0] HOLD_CYC = CYC_W'(HOLD_CYCLES);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("exec_sequencer: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (EXEC_CYCLES < 2) begin : g_bad_exec
        $error("exec_sequencer: EXEC_CYCLES must be at least 2");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES >= EXEC_CYCLES) begin : g_bad_hold
        $error("exec_sequencer: HOLD_CYCLES must satisfy 1 <= HOLD_CYCLES < EXEC_CYCLES");
    end

    seq_state_t         state;
    seq_state_t         state_next;
    logic [CYC_W-1:0]   cyc;
    logic [INST_W-1:0]  inst_reg;
    logic               last_cyc;
    logic               pop;
    logic               push;
    logic               drop;
    logic [INST_W-1:0]  fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;

    inst_fifo #(
        .INST_W     (INST_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (inst_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign push = inst_valid && (!fifo_full || pop);
    assign drop = inst_valid && fifo_full && !pop;

    assign last_cyc   = (cyc == LAST_CYC);
    assign inst_ready = !rst && !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (last_cyc) begin
`ifdef EXEC_SEQ_BATCH_EN
                    // Chain straight into the next window; cyc restarts on pop.
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_next = DUMP;
                    end
`else
                    state_next = DUMP;
`endif
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc      <= '0;
            inst_reg <= NOP;
            cpu_en   <= 1'b0;
            inst_out <= NOP;
            dump_req <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                inst_reg <= fifo_rdata;
                cyc      <= '0;
            end else if (state == EXEC && !last_cyc) begin
                cyc <= cyc + 1'b1;
            end
            cpu_en   <= (state == EXEC);
            inst_out <= (state == EXEC && cyc < HOLD_CYC) ? inst_reg : NOP;
            dump_req <= (state == DUMP);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

    localparam int          INST_W      = 32;
    localparam int          FIFO_DEPTH  = 4;
    localparam int          EXEC_CYCLES = 10;
    localparam int          HOLD_CYCLES = 2;
    localparam int          CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              inst_valid = 1'b0;
    logic [31:0]       inst_data = '0;
    logic              dump_ready = 1'b0;
    logic              inst_ready;
    logic              cpu_en;
    logic [31:0]       inst_out;
    logic              dump_req;
    logic              busy;
    logic              overflow;
    logic [CNT_W-1:0]  fifo_count;

    exec_sequencer #(
        .INST_W      (INST_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .EXEC_CYCLES (EXEC_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES),
        .NOP         (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .cpu_en     (cpu_en),
        .inst_out   (inst_out),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of pending words plus "cycles of window left"
    // and a pending-dump flag; outputs are what the spec says is visible one
    // clock after each of those conditions holds.
    logic [31:0] m_q[$];
    bit          m_live = 1'b0;
    bit          m_ovf, m_dumping, m_cpu, m_dreq;
    int          m_rem;
    logic [31:0] m_cur, m_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit          pop_now;
        logic [31:0] head;
        head = NOP;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_dumping = 0; m_rem = 0; m_cpu = 0; m_dreq = 0;
            m_cur = NOP; m_out = NOP; m_live = 1;
            return;
        end
        if (!m_live) return;
        m_cpu  = (m_rem > 0);
        m_out  = (m_rem > EXEC_CYCLES - HOLD_CYCLES) ? m_cur : NOP;
        m_dreq = m_dumping;
        pop_now = 0;
        if (m_rem == 0 && !m_dumping) pop_now = (m_q.size() > 0);
`ifdef EXEC_SEQ_BATCH_EN
        if (m_rem == 1) pop_now = (m_q.size() > 0);
`endif
        if (pop_now) head = m_q.pop_front();
        if (inst_valid) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(inst_data);
            else m_ovf = 1;
        end
        if (m_rem > 1) begin
            m_rem--;
        end else if (m_rem == 1) begin
            if (pop_now) begin m_rem = EXEC_CYCLES; m_cur = head; end
            else begin m_rem = 0; m_dumping = 1; end
        end else if (m_dumping) begin
            if (dump_ready) m_dumping = 0;
        end else if (pop_now) begin
            m_rem = EXEC_CYCLES; m_cur = head;
        end
    endtask

    task automatic check_model();
        bit e_busy, e_ready;
        e_busy  = (m_rem > 0) || m_dumping || (m_q.size() > 0);
        e_ready = !rst && (m_q.size() < FIFO_DEPTH);
        chk("model", 64'({cpu_en, inst_out, dump_req, busy, overflow, inst_ready, fifo_count}),
                     64'({m_cpu, m_out, m_dreq, e_busy, m_ovf, e_ready, CNT_W'(m_q.size())}));
    endtask

    // One clock: inputs were set at the previous falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_live) check_model();
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return dump_req;
            1:       return cpu_en;
            default: return !busy && !dump_req;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int budget);
        for (int i = 0; i < budget && !cond(which); i++) step();
        chk(name, 64'(cond(which)), 64'd1);
    endtask

    task automatic push_one(input logic [31:0] w);
        inst_valid = 1'b1; inst_data = w;
        step();
        inst_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; inst_valid = 1'b0; dump_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic        e_cpu;
        logic [31:0] e_out;
        logic        e_dreq;
        logic        e_busy;
        int          e_cnt;
    } vec_t;

    vec_t        tab[15];
    logic [31:0] got[4];
    logic [31:0] pw[6];
    logic [31:0] bw[3];

    initial begin
        automatic logic [31:0] i0 = 32'h0050_0093;
        automatic int n, run, max_run, total, rises;
        automatic bit prev, prev_d, seen;

        // Reset values
        step();
        step();
        chk("rst_inst_ready", 64'(inst_ready), 64'd0);
        chk("rst_cpu_en",     64'(cpu_en),     64'd0);
        chk("rst_inst_out",   64'(inst_out),   64'(NOP));
        chk("rst_dump_req",   64'(dump_req),   64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_overflow",   64'(overflow),   64'd0);
        chk("rst_count",      64'(fifo_count), 64'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 64'(inst_ready), 64'd1);

        // Single instruction, cycle by cycle
        for (int i = 0; i < 15; i++)
            tab[i] = '{v:1'b0, d:32'h0, rdy:1'b0, e_cpu:1'b0, e_out:NOP, e_dreq:1'b0, e_busy:1'b1, e_cnt:0};
        tab[0].v = 1'b1; tab[0].d = i0; tab[0].e_cnt = 1;
        tab[2].e_cpu = 1'b1; tab[2].e_out = i0;
        tab[3].e_cpu = 1'b1; tab[3].e_out = i0;
        for (int i = 4; i < 12; i++) tab[i].e_cpu = 1'b1;
        tab[12].e_dreq = 1'b1;
        tab[13].rdy = 1'b1; tab[13].e_dreq = 1'b1; tab[13].e_busy = 1'b0;
        tab[14].e_busy = 1'b0;
        for (int i = 0; i < 15; i++) begin
            inst_valid = tab[i].v; inst_data = tab[i].d; dump_ready = tab[i].rdy;
            step();
            chk($sformatf("vec%0d", i),
                64'({cpu_en, inst_out, dump_req, busy, fifo_count}),
                64'({tab[i].e_cpu, tab[i].e_out, tab[i].e_dreq, tab[i].e_busy, CNT_W'(tab[i].e_cnt)}));
        end
        inst_valid = 1'b0; dump_ready = 1'b0;

        // dump_req held while dump_ready stays low
        push_one(32'h0010_0113);
        wait_for("dump_wait", 0, 40);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("dump_hold%0d", i), 64'(dump_req), 64'd1);
        end
        dump_ready = 1'b1;
        step();
        chk("dump_accept_req",  64'(dump_req), 64'd1);
        chk("dump_accept_busy", 64'(busy),     64'd0);
        dump_ready = 1'b0;
        step();
        chk("dump_fall", 64'(dump_req), 64'd0);

        // Five strobes while waiting in DUMP: fifth dropped
        for (int k = 0; k < 6; k++) pw[k] = 32'h0020_0193 + 32'(k << 20);
        push_one(pw[0]);
        wait_for("ovf_dump_wait", 0, 40);
        for (int k = 1; k <= 5; k++) begin
            inst_valid = 1'b1; inst_data = pw[k];
            step();
            if (k == 4) chk("ovf_before", 64'(overflow), 64'd0);
        end
        inst_valid = 1'b0;
        chk("ovf_set",   64'(overflow),   64'd1);
        chk("ovf_count", 64'(fifo_count), 64'd4);
        dump_ready = 1'b1;
        n = 0; prev = cpu_en;
        for (int i = 0; i < 200 && n < 4; i++) begin
            step();
            if (cpu_en && !prev) begin got[n] = inst_out; n++; end
            prev = cpu_en;
        end
        chk("ovf_windows", 64'(n), 64'd4);
        for (int k = 0; k < 4; k++) chk($sformatf("ovf_order%0d", k), 64'(got[k]), 64'(pw[k+1]));
        wait_for("ovf_drain", 2, 100);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        do_reset();

        // Push coinciding with pop at full
        push_one(32'h0030_0213);
        wait_for("pp_dump_wait", 0, 40);
        for (int k = 0; k < 4; k++) push_one(32'h0040_0293 + 32'(k));
        chk("pp_full", 64'(fifo_count), 64'd4);
        dump_ready = 1'b1;
        step();
        chk("pp_accept", 64'(fifo_count), 64'd4);
        dump_ready = 1'b0;
        push_one(32'h0050_0313);
        chk("pp_count", 64'(fifo_count), 64'd4);
        chk("pp_ovf",   64'(overflow),   64'd0);
        dump_ready = 1'b1;
        wait_for("pp_drain", 2, 300);
        dump_ready = 1'b0;

        // Reset in the middle of a window with two queued
        push_one(32'h0060_0393);
        wait_for("rx_cpu_wait", 1, 20);
        push_one(32'h0070_0413);
        push_one(32'h0080_0493);
        chk("rx_queued", 64'(fifo_count), 64'd2);
        step();
        step();
        rst = 1'b1;
        step();
        chk("rx_cpu_en", 64'(cpu_en),     64'd0);
        chk("rx_count",  64'(fifo_count), 64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dump_req) seen = 1'b1;
        end
        chk("rx_no_dump", 64'(seen), 64'd0);
        chk("rx_idle",    64'(busy), 64'd0);

        // Three queued instructions with the transmitter always ready
        bw[0] = 32'h0090_0513; bw[1] = 32'h00A0_0593; bw[2] = 32'h00B0_0613;
        dump_ready = 1'b1;
        run = 0; max_run = 0; total = 0; rises = 0; prev_d = 1'b0;
        for (int i = 0; i < 120; i++) begin
            inst_valid = (i < 3);
            inst_data  = bw[i % 3];
            step();
            if (cpu_en) begin
                run++; total++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (dump_req && !prev_d) rises++;
            prev_d = dump_req;
        end
        inst_valid = 1'b0;
        chk("seq_total", 64'(total), 64'(3 * EXEC_CYCLES));
`ifdef EXEC_SEQ_BATCH_EN
        chk("seq_run",   64'(max_run), 64'(3 * EXEC_CYCLES));
        chk("seq_dumps", 64'(rises),   64'd1);
`else
        chk("seq_run",   64'(max_run), 64'(EXEC_CYCLES));
        chk("seq_dumps", 64'(rises),   64'd3);
`endif

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            inst_valid = ($urandom_range(0, 5) == 0);
            inst_data  = $urandom;
            dump_ready = $urandom_range(0, 2) != 0;
            step();
        end
        rst = 1'b0; inst_valid = 1'b0; dump_ready = 1'b1;
        wait_for("final_drain", 2, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Parametrised instruction-execution sequencer between the UART instruction receiver and the processor. It buffers received instructions in a small FIFO and runs each one on the processor through a clock-enable window of programmable length, presenting the instruction for a hold period and NOPs afterwards. It then requests a register-file dump from the transmitter through a ready/request handshake. Unlike the single-shot sequencing it replaces, it queues back-to-back instructions, drops and flags overflow instead of corrupting state, and optionally batches dumps.

## Interface
- INST_W, 32, instruction width
- FIFO_DEPTH, 4, queued instructions; power of two, ≥2
- EXEC_CYCLES, 10, cycles cpu_en is high per instruction; ≥2
- HOLD_CYCLES, 2, leading cycles of the window that present the instruction; 1 ≤ HOLD_CYCLES < EXEC_CYCLES
- NOP, 32'h00000013, word presented after the hold period and when idle

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- inst_valid  in  1  one-cycle strobe: inst_data is a complete instruction
- inst_data  in  INST_W  received instruction
- inst_ready  out  1  FIFO not full; informational only, because the receiver cannot stall
- cpu_en  out  1  processor clock enable
- inst_out  out  INST_W  registered instruction word to the processor
- dump_req  out  1  register-file dump request
- dump_ready  in  1  transmitter accepts the dump
- busy  out  1  state ≠ IDLE, or FIFO not empty
- overflow  out  1  sticky: an instruction was dropped
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- Push: inst_valid && count < FIFO_DEPTH.
- Push with FIFO full: data is dropped, count is unchanged, overflow is set until rst.
- Push and pop in the same cycle: count is unchanged, and both succeed even at full.
- States:
  - IDLE: if count > 0, pop the head into inst_reg, clear cyc, go to EXEC.
  - EXEC: cpu_en=1. inst_out = inst_reg while cyc < HOLD_CYCLES, otherwise NOP. cyc increments each cycle. At cyc == EXEC_CYCLES-1, go to DUMP, or apply the batch rule (see Configuration).
  - DUMP: dump_req=1, held until dump_ready is sampled high. On that cycle go to IDLE; dump_req falls the following cycle.
- dump_ready while not in DUMP is ignored.
- cyc is $clog2(EXEC_CYCLES) bits wide and never wraps; it is cleared on entry to EXEC.

## Timing
- Reset values: state IDLE, FIFO empty, cpu_en 0, dump_req 0, inst_out NOP, busy 0, overflow 0, fifo_count 0. inst_ready is 0 while rst is high.
- Reset mid-EXEC or mid-DUMP:
  - abort immediately
  - flush the queue
  - no dump is issued
- All outputs are registered except inst_ready and busy, which decode registered state.
- Latency:
  - inst_valid accepted at edge N → IDLE sees it at N+1 → cpu_en high from edge N+2.
  - inst_out equals the instruction over the same cycles as the first HOLD_CYCLES cycles of cpu_en.
- cpu_en is high for exactly EXEC_CYCLES consecutive cycles per instruction.
- Per-instruction mode: minimum spacing between windows is EXEC_CYCLES + 2 cycles (one DUMP cycle with dump_ready already high, plus one IDLE cycle).

## Configuration
- EXEC_SEQ_BATCH_EN defined:
  - At the end of EXEC, if count > 0, pop the next instruction and re-enter EXEC directly, with cpu_en continuous and no dump.
  - DUMP is entered only when the FIFO is empty at the end of EXEC.
- EXEC_SEQ_BATCH_EN undefined: DUMP follows every instruction.

## Structure
- Package exec_seq_pkg:
  - state enum (IDLE, EXEC, DUMP)
  - default NOP constant
  - width helper for count
- Sub-module inst_fifo:
  - synchronous FIFO parametrised by INST_W and FIFO_DEPTH
  - ports push, pop, data in/out, count, full, empty
  - the sequencer owns the overflow policy
- Elaboration-time checks enforce the parameter constraints listed under Interface.

## Test plan
- Single instruction 32'h00500093 after reset:
  - cpu_en high for 10 cycles starting 2 cycles after the strobe
  - inst_out = 32'h00500093 for the first 2 of those cycles, then NOP
  - dump_req rises after the window
- dump_ready held low for 7 cycles, then pulsed: dump_req stays high for exactly those cycles, drops one cycle after acceptance, and busy then falls.
- Five strobes back-to-back with DEPTH=4 and the sequencer busy in DUMP: the fifth is dropped, overflow=1, fifo_count=4, and four executions follow in order.
- Push coinciding with a pop at count=4: count stays 4, overflow stays 0.
- rst asserted at EXEC cycle 5 with 2 queued: next cycle cpu_en=0, fifo_count=0, no dump_req ever asserted.
- With EXEC_SEQ_BATCH_EN, three queued instructions: cpu_en high for 30 contiguous cycles, exactly one dump_req at the end.
